uart_receiver: RTL and testbench

UART_RECEIVER -- requirements
Module: uart_receiver

---
 rtl/uart_receiver_if.sv | 27 ++
 rtl/uart_receiver.sv | 139 +++++++++++++
 tb/tb_uart_receiver.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/uart_receiver_if.sv
`default_nettype none
// ============================================================================
// Module      : uart_receiver_if
// Description : Serial line and received-byte signals of the 8N1 UART receiver.
// Revision    : 1.0 - initial release
// ============================================================================
interface uart_receiver_if;
    logic       rxd;
    logic [7:0] data;
    logic       dataReady;
    logic       frameError;

    modport master (
        input  rxd,
        output data,
        output dataReady,
        output frameError
    );

    modport slave (
        output rxd,
        input  data,
        input  dataReady,
        input  frameError
    );
endinterface
`default_nettype wire

// File: rtl/uart_receiver.sv
`default_nettype none
// ============================================================================
// Module      : uart_receiver
// Description : 8N1 UART receiver that samples at bit centres, flags bad stop bits.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_receiver #(
    parameter int CLK_HZ = 100000000,
    parameter int BAUD   = 115200
) (
    input  wire logic       clk,
    input  wire logic       rst,
    uart_receiver_if.master bus
);
    localparam int c_DIV   = CLK_HZ / BAUD;
    localparam int c_HALF  = c_DIV / 2;
    localparam int c_CNT_W = $clog2(c_DIV);

    localparam logic [c_CNT_W-1:0] c_DIV_M1  = c_CNT_W'(c_DIV - 1);
    localparam logic [c_CNT_W-1:0] c_HALF_M1 = c_CNT_W'(c_HALF - 1);

    localparam logic [2:0] c_ST_IDLE  = 3'd0;
    localparam logic [2:0] c_ST_START = 3'd1;
    localparam logic [2:0] c_ST_DATA  = 3'd2;
    localparam logic [2:0] c_ST_STOP  = 3'd3;
    localparam logic [2:0] c_ST_BREAK = 3'd4;

    logic               r_sync1;
    logic               r_sync2;
    logic [2:0]         r_state;
    logic [2:0]         w_state_next;
    logic [c_CNT_W-1:0] r_cnt;
    logic [c_CNT_W-1:0] w_cnt_next;
    logic [2:0]         r_idx;
    logic [2:0]         w_idx_next;
    logic [7:0]         r_shift;
    logic [7:0]         w_shift_next;
    logic [7:0]         r_data;
    logic [7:0]         w_data_next;
    logic               r_ready;
    logic               w_ready_next;
    logic               r_ferr;
    logic               w_ferr_next;
    logic               w_half_end;
    logic               w_bit_end;

    assign w_half_end = (r_cnt == c_HALF_M1);
    assign w_bit_end  = (r_cnt == c_DIV_M1);

    // Synchronizer idles high so a reset release never looks like a start bit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= bus.rxd;
            r_sync2 <= r_sync1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_ST_IDLE:  if (!r_sync2) w_state_next = c_ST_START;
            c_ST_START: if (w_half_end) w_state_next = r_sync2 ? c_ST_IDLE : c_ST_DATA;
            c_ST_DATA:  if (w_bit_end && (r_idx == 3'd7)) w_state_next = c_ST_STOP;
            c_ST_STOP:  if (w_bit_end) w_state_next = r_sync2 ? c_ST_IDLE : c_ST_BREAK;
            c_ST_BREAK: if (r_sync2) w_state_next = c_ST_IDLE;
            default:    w_state_next = c_ST_IDLE;
        endcase
    end

    always_comb begin
        w_cnt_next   = r_cnt + 1'b1;
        w_idx_next   = r_idx;
        w_shift_next = r_shift;
        w_data_next  = r_data;
        w_ready_next = 1'b0;
        w_ferr_next  = 1'b0;
        case (r_state)
            c_ST_START: begin
                if (w_half_end) begin
                    w_cnt_next = '0;
                    w_idx_next = 3'd0;
                end
            end
            c_ST_DATA: begin
                if (w_bit_end) begin
                    w_cnt_next            = '0;
                    w_shift_next[r_idx]   = r_sync2;
                    if (r_idx != 3'd7) w_idx_next = r_idx + 3'd1;
                end
            end
            c_ST_STOP: begin
                if (w_bit_end) begin
                    w_cnt_next = '0;
                    if (r_sync2) begin
                        w_data_next  = r_shift;
                        w_ready_next = 1'b1;
                    end else begin
                        w_ferr_next = 1'b1;
                    end
                end
            end
            default: w_cnt_next = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt   <= '0;
            r_idx   <= 3'd0;
            r_shift <= 8'h00;
            r_data  <= 8'h00;
            r_ready <= 1'b0;
            r_ferr  <= 1'b0;
        end else begin
            r_cnt   <= w_cnt_next;
            r_idx   <= w_idx_next;
            r_shift <= w_shift_next;
            r_data  <= w_data_next;
            r_ready <= w_ready_next;
            r_ferr  <= w_ferr_next;
        end
    end

    assign bus.data       = r_data;
    assign bus.dataReady  = r_ready;
    assign bus.frameError = r_ferr;
endmodule
`default_nettype wire

// File: tb/tb_uart_receiver.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_receiver
// Description : Directed self-checking bench for uart_receiver at DIV=16.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_receiver;
    localparam int c_BIT = 16;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    int   cyc;
    int   ready_cnt;
    int   ferr_cnt;
    int   both_cnt;
    int   ready_cycle;
    int   frame_start;
    logic [7:0] ready_q[$];

    uart_receiver_if bus ();

    uart_receiver #(.CLK_HZ(1600), .BAUD(100)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (bus.dataReady) begin
            ready_cnt++;
            ready_cycle = cyc;
            ready_q.push_back(bus.data);
        end
        if (bus.frameError) ferr_cnt++;
        if (bus.dataReady && bus.frameError) both_cnt++;
    end

    task automatic send_bit(input logic v);
        bus.rxd = v;
        repeat (c_BIT) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        frame_start = cyc;
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(stop);
    endtask

    task automatic idle(input int n);
        bus.rxd = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_mon();
        ready_cnt = 0;
        ferr_cnt  = 0;
        ready_q.delete();
    endtask

    task automatic test_reset();
        rst     = 1'b0;
        bus.rxd = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (bus.data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h want 00", bus.data); end
        checks++; if (bus.dataReady !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", bus.dataReady); end
        checks++; if (bus.frameError !== 1'b0) begin errors++; $display("FAIL reset_ferr: got %b want 0", bus.frameError); end
        rst = 1'b1;
        idle(20);
    endtask

    task automatic test_single_byte();
        clear_mon();
        send_frame(8'h41, 1'b1);
        idle(20);
        checks++; if (ready_cnt !== 1) begin errors++; $display("FAIL single_count: got %0d want 1", ready_cnt); end
        checks++; if (bus.data !== 8'h41) begin errors++; $display("FAIL single_data: got %h want 41", bus.data); end
        checks++; if (ferr_cnt !== 0) begin errors++; $display("FAIL single_ferr: got %0d want 0", ferr_cnt); end
        // stop bit occupies cycles 144..159 after the start edge
        checks++;
        if ((ready_cycle - frame_start) < 144 || (ready_cycle - frame_start) > 159) begin
            errors++; $display("FAIL single_timing: got %0d want 144..159", ready_cycle - frame_start);
        end
    endtask

    task automatic test_glitch();
        clear_mon();
        bus.rxd = 1'b0;
        repeat (4) @(negedge clk);
        idle(40);
        checks++; if (ready_cnt !== 0) begin errors++; $display("FAIL glitch_ready: got %0d want 0", ready_cnt); end
        checks++; if (ferr_cnt !== 0) begin errors++; $display("FAIL glitch_ferr: got %0d want 0", ferr_cnt); end
        checks++; if (bus.data !== 8'h41) begin errors++; $display("FAIL glitch_data: got %h want 41", bus.data); end
    endtask

    task automatic test_frame_error();
        clear_mon();
        send_frame(8'h55, 1'b0);
        bus.rxd = 1'b0;
        repeat (100) @(negedge clk);
        idle(20);
        checks++; if (ferr_cnt !== 1) begin errors++; $display("FAIL ferr_count: got %0d want 1", ferr_cnt); end
        checks++; if (ready_cnt !== 0) begin errors++; $display("FAIL ferr_ready: got %0d want 0", ready_cnt); end
        checks++; if (bus.data !== 8'h41) begin errors++; $display("FAIL ferr_data: got %h want 41", bus.data); end
        clear_mon();
        send_frame(8'h7E, 1'b1);
        idle(20);
        checks++; if (ready_cnt !== 1) begin errors++; $display("FAIL recover_count: got %0d want 1", ready_cnt); end
        checks++; if (bus.data !== 8'h7E) begin errors++; $display("FAIL recover_data: got %h want 7e", bus.data); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp [3];
        exp[0] = 8'h1B; exp[1] = 8'h5B; exp[2] = 8'h48;
        clear_mon();
        for (int i = 0; i < 3; i++) send_frame(exp[i], 1'b1);
        idle(20);
        checks++; if (ready_q.size() !== 3) begin errors++; $display("FAIL b2b_count: got %0d want 3", ready_q.size()); end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (i >= ready_q.size()) begin
                errors++; $display("FAIL b2b_data%0d: got none want %h", i, exp[i]);
            end else if (ready_q[i] !== exp[i]) begin
                errors++; $display("FAIL b2b_data%0d: got %h want %h", i, ready_q[i], exp[i]);
            end
        end
    endtask

    task automatic test_reset_midframe();
        logic [7:0] b;
        b = 8'h33;
        clear_mon();
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(b[i]);
        bus.rxd = b[4];
        repeat (c_BIT / 2) @(negedge clk);
        rst = 1'b0;
        #1;
        checks++; if (bus.data !== 8'h00) begin errors++; $display("FAIL midrst_data: got %h want 00", bus.data); end
        checks++; if (bus.dataReady !== 1'b0 || bus.frameError !== 1'b0) begin
            errors++; $display("FAIL midrst_pulses: got %b%b want 00", bus.dataReady, bus.frameError);
        end
        repeat (3) @(negedge clk);
        rst = 1'b1;
        idle(200);
        checks++; if (ready_cnt !== 0 || ferr_cnt !== 0) begin
            errors++; $display("FAIL midrst_nopulse: got %0d/%0d want 0/0", ready_cnt, ferr_cnt);
        end
        checks++; if (bus.data !== 8'h00) begin errors++; $display("FAIL midrst_hold: got %h want 00", bus.data); end
        send_frame(8'h0A, 1'b1);
        idle(20);
        checks++; if (ready_cnt !== 1) begin errors++; $display("FAIL after_rst_count: got %0d want 1", ready_cnt); end
        checks++; if (bus.data !== 8'h0A) begin errors++; $display("FAIL after_rst_data: got %h want 0a", bus.data); end
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        cyc       = 0;
        both_cnt  = 0;
        ready_cnt = 0;
        ferr_cnt  = 0;
        ready_cycle = 0;
        frame_start = 0;
        rst     = 1'b0;
        bus.rxd = 1'b1;
        @(negedge clk);
        test_reset();
        test_single_byte();
        test_glitch();
        test_frame_error();
        test_back_to_back();
        test_reset_midframe();
        checks++; if (both_cnt !== 0) begin errors++; $display("FAIL exclusive_pulses: got %0d want 0", both_cnt); end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
